// File: rtl/channel_fir_iq.sv
// Complex channel low-pass FIR with decimation, between the read_iq FIFOs and the FM demod FIFOs.
// I and Q share one real coefficient set; a single MAC step per cycle walks all taps once per output.
module channel_fir_iq #(
  parameter int DATA_SIZE = 32,
  parameter int BITS      = 10,
  parameter int TAPS      = 20,
  parameter int DECIM     = 1,
  parameter logic signed [DATA_SIZE-1:0] CHANNEL_COEFFS [TAPS] = '{
    -3, -6, -4, 5, 20, 38, 58, 75, 88, 95,
    95, 88, 75, 58, 38, 20, 5, -4, -6, -3
  }
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_in_empty,
  input  logic                 q_in_empty,
  input  logic [DATA_SIZE-1:0] i_in_dout,
  input  logic [DATA_SIZE-1:0] q_in_dout,
  output logic                 i_in_rd_en,
  output logic                 q_in_rd_en,
  input  logic                 i_out_full,
  input  logic                 q_out_full,
  output logic                 i_out_wr_en,
  output logic                 q_out_wr_en,
  output logic [DATA_SIZE-1:0] i_out_din,
  output logic [DATA_SIZE-1:0] q_out_din
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW = 2 * DATA_SIZE;
  localparam logic [CW-1:0] DECIM_LAST = CW'(DECIM - 1);
  localparam logic [TW-1:0] TAP_LAST   = TW'(TAPS - 1);
  localparam logic signed [PW-1:0] BIAS = {{(PW-BITS){1'b0}}, {BITS{1'b1}}};

  typedef enum logic [1:0] {S_FILL, S_MAC, S_WRITE} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               count_q, count_d;
  logic [TW-1:0]               tap_idx_q, tap_idx_d;
  logic signed [DATA_SIZE-1:0] acc_i_q, acc_i_d;
  logic signed [DATA_SIZE-1:0] acc_q_q, acc_q_d;
  logic [DATA_SIZE-1:0]        i_din_q, i_din_d;
  logic [DATA_SIZE-1:0]        q_din_q, q_din_d;
  logic                        rd_en_q, rd_en_d;
  logic                        wr_en_q, wr_en_d;
  logic                        shift_en;
  logic signed [DATA_SIZE-1:0] hist_i_q [TAPS];
  logic signed [DATA_SIZE-1:0] hist_q_q [TAPS];
  logic signed [DATA_SIZE-1:0] coeff, sample_i, sample_q;
  logic signed [PW-1:0]        prod_i, prod_q;

  // Dequantize: divide by 2^BITS rounding toward zero, then keep the low DATA_SIZE bits.
  function automatic logic signed [DATA_SIZE-1:0] dq(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] adj;
    adj = p[PW-1] ? p + BIAS : p;
    return DATA_SIZE'(adj >>> BITS);
  endfunction

  always_comb begin
    coeff    = CHANNEL_COEFFS[tap_idx_q];
    sample_i = hist_i_q[tap_idx_q];
    sample_q = hist_q_q[tap_idx_q];
    prod_i   = PW'(coeff) * PW'(sample_i);
    prod_q   = PW'(coeff) * PW'(sample_q);
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    tap_idx_d = tap_idx_q;
    acc_i_d   = acc_i_q;
    acc_q_d   = acc_q_q;
    i_din_d   = i_din_q;
    q_din_d   = q_din_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      S_FILL: begin
        // rd_en is registered, so skip the cycle in which the previous pop is still retiring.
        if (!i_in_empty && !q_in_empty && !rd_en_q) begin
          rd_en_d  = 1'b1;
          shift_en = 1'b1;
          if (count_q == DECIM_LAST) begin
            count_d   = '0;
            tap_idx_d = '0;
            state_d   = S_MAC;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        acc_i_d = acc_i_q + dq(prod_i);
        acc_q_d = acc_q_q + dq(prod_q);
        if (tap_idx_q == TAP_LAST) begin
          state_d = S_WRITE;
        end else begin
          tap_idx_d = tap_idx_q + 1'b1;
        end
      end
      S_WRITE: begin
        i_din_d = acc_i_q;
        q_din_d = acc_q_q;
        if (!i_out_full && !q_out_full) begin
          wr_en_d = 1'b1;
          acc_i_d = '0;
          acc_q_d = '0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FILL;
      count_q   <= '0;
      tap_idx_q <= '0;
      acc_i_q   <= '0;
      acc_q_q   <= '0;
      i_din_q   <= '0;
      q_din_q   <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tap_idx_q <= tap_idx_d;
      acc_i_q   <= acc_i_d;
      acc_q_q   <= acc_q_d;
      i_din_q   <= i_din_d;
      q_din_q   <= q_din_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
    end
  end

  // Sample history: tap 0 holds the newest pair.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_i_q[0] <= '0;
      hist_q_q[0] <= '0;
    end else if (shift_en) begin
      hist_i_q[0] <= i_in_dout;
      hist_q_q[0] <= q_in_dout;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < TAPS; gi++) begin : g_hist
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          hist_i_q[gi] <= '0;
          hist_q_q[gi] <= '0;
        end else if (shift_en) begin
          hist_i_q[gi] <= hist_i_q[gi-1];
          hist_q_q[gi] <= hist_q_q[gi-1];
        end
      end
    end
  endgenerate

  assign i_in_rd_en  = rd_en_q;
  assign q_in_rd_en  = rd_en_q;
  assign i_out_wr_en = wr_en_q;
  assign q_out_wr_en = wr_en_q;
  assign i_out_din   = i_din_q;
  assign q_out_din   = q_din_q;

endmodule

// File: tb/tb_channel_fir_iq.sv
// Directed bench for channel_fir_iq: one DECIM=1 instance for impulse/step/rounding/backpressure/reset,
// one DECIM=4 instance for decimated step response. Behavioural FWFT FIFOs feed both.
module tb_channel_fir_iq;

  localparam int TAPS = 20;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Coefficient table as hand-entered; its total is 732.
  int coef [TAPS] = '{-3, -6, -4, 5, 20, 38, 58, 75, 88, 95,
                      95, 88, 75, 58, 38, 20, 5, -4, -6, -3};
  // DECIM=4 step (I=+1.0, Q=-1.0): sums of coef[0..4g+3]
  int dec_exp [6] = '{-8, 183, 549, 740, 732, 732};

  // ---------------- instance A (DECIM=1) ----------------
  logic        a_i_empty, a_q_empty, a_i_rd_en, a_q_rd_en;
  logic        a_i_full, a_q_full, a_i_wr_en, a_q_wr_en;
  logic [31:0] a_i_dout, a_q_dout, a_i_din, a_q_din;
  logic [31:0] a_i_mem [256];
  logic [31:0] a_q_mem [256];
  logic [31:0] a_out_i [256];
  logic [31:0] a_out_q [256];
  int a_wi = 0, a_wq = 0, a_ri = 0, a_rq = 0, a_n = 0;
  int a_overlap = 0, a_pair_err = 0;

  assign a_i_empty = (a_ri >= a_wi);
  assign a_q_empty = (a_rq >= a_wq);
  assign a_i_dout  = a_i_mem[a_ri[7:0]];
  assign a_q_dout  = a_q_mem[a_rq[7:0]];

  channel_fir_iq u_dut (
    .clock       (clock),
    .reset       (reset),
    .i_in_empty  (a_i_empty),
    .q_in_empty  (a_q_empty),
    .i_in_dout   (a_i_dout),
    .q_in_dout   (a_q_dout),
    .i_in_rd_en  (a_i_rd_en),
    .q_in_rd_en  (a_q_rd_en),
    .i_out_full  (a_i_full),
    .q_out_full  (a_q_full),
    .i_out_wr_en (a_i_wr_en),
    .q_out_wr_en (a_q_wr_en),
    .i_out_din   (a_i_din),
    .q_out_din   (a_q_din)
  );

  always @(posedge clock) begin
    if (a_i_rd_en) a_ri <= a_ri + 1;
    if (a_q_rd_en) a_rq <= a_rq + 1;
  end

  always @(negedge clock) begin
    if (a_i_rd_en != a_q_rd_en || a_i_wr_en != a_q_wr_en) a_pair_err <= a_pair_err + 1;
    if (a_i_rd_en && a_i_wr_en) a_overlap <= a_overlap + 1;
    if (a_i_wr_en) begin
      a_out_i[a_n[7:0]] <= a_i_din;
      a_out_q[a_n[7:0]] <= a_q_din;
      a_n <= a_n + 1;
      $display("[TB] A out %0d: I=%0d Q=%0d", a_n, $signed(a_i_din), $signed(a_q_din));
    end
  end

  // ---------------- instance B (DECIM=4) ----------------
  logic        b_i_empty, b_q_empty, b_i_rd_en, b_q_rd_en;
  logic        b_i_full, b_q_full, b_i_wr_en, b_q_wr_en;
  logic [31:0] b_i_dout, b_q_dout, b_i_din, b_q_din;
  logic [31:0] b_i_mem [64];
  logic [31:0] b_q_mem [64];
  logic [31:0] b_out_i [64];
  logic [31:0] b_out_q [64];
  int b_wi = 0, b_ri = 0, b_rq = 0, b_n = 0;

  assign b_i_empty = (b_ri >= b_wi);
  assign b_q_empty = (b_rq >= b_wi);
  assign b_i_dout  = b_i_mem[b_ri[5:0]];
  assign b_q_dout  = b_q_mem[b_rq[5:0]];

  channel_fir_iq #(.DECIM(4)) u_dec (
    .clock       (clock),
    .reset       (reset),
    .i_in_empty  (b_i_empty),
    .q_in_empty  (b_q_empty),
    .i_in_dout   (b_i_dout),
    .q_in_dout   (b_q_dout),
    .i_in_rd_en  (b_i_rd_en),
    .q_in_rd_en  (b_q_rd_en),
    .i_out_full  (b_i_full),
    .q_out_full  (b_q_full),
    .i_out_wr_en (b_i_wr_en),
    .q_out_wr_en (b_q_wr_en),
    .i_out_din   (b_i_din),
    .q_out_din   (b_q_din)
  );

  always @(posedge clock) begin
    if (b_i_rd_en) b_ri <= b_ri + 1;
    if (b_q_rd_en) b_rq <= b_rq + 1;
  end

  always @(negedge clock) begin
    if (b_i_wr_en) begin
      b_out_i[b_n[5:0]] <= b_i_din;
      b_out_q[b_n[5:0]] <= b_q_din;
      b_n <= b_n + 1;
      $display("[TB] B out %0d: I=%0d Q=%0d", b_n, $signed(b_i_din), $signed(b_q_din));
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] iv, input logic [31:0] qv);
    a_i_mem[a_wi[7:0]] = iv;
    a_q_mem[a_wq[7:0]] = qv;
    a_wi = a_wi + 1;
    a_wq = a_wq + 1;
  endtask

  task automatic wait_a(input int target, input int budget);
    int c = 0;
    while (a_n < target && c < budget) begin
      @(negedge clock);
      c++;
    end
    @(negedge clock);
  endtask

  task automatic wait_pop_a(input int target, input int budget);
    int c = 0;
    while (a_ri < target && c < budget) begin
      @(negedge clock);
      c++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum;
    a_i_full = 1'b0; a_q_full = 1'b0;
    b_i_full = 1'b0; b_q_full = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_rd_en", int'(a_i_rd_en), 0);
    chk("rst_wr_en", int'(a_i_wr_en), 0);
    chk("rst_i_din", int'(a_i_din), 0);
    chk("rst_q_din", int'(a_q_din), 0);
    reset = 1'b1;

    // Decimating instance runs in parallel: I=+1.0, Q=-1.0 constant, 24 pairs
    for (int k = 0; k < 24; k++) begin
      b_i_mem[k] = 32'h0000_0400;
      b_q_mem[k] = 32'hFFFF_FC00;
    end
    b_wi = 24;

    // Skewed inputs: I ready, Q empty -> nothing popped
    @(negedge clock);
    a_i_mem[0] = 32'h400;
    a_wi = 1;
    repeat (20) @(negedge clock);
    chk("skew_i_pops", a_ri, 0);
    chk("skew_q_pops", a_rq, 0);

    // Impulse on I (completes pair 0 with Q=0), then zeros
    a_q_mem[0] = 32'h0;
    a_wq = 1;
    for (int k = 1; k < 30; k++) push_a(32'h0, 32'h0);
    wait_a(30, 2000);
    chk("imp_count", a_n, 30);
    for (int k = 0; k < 30; k++) begin
      chk($sformatf("imp_i[%0d]", k), int'(a_out_i[k]), (k < TAPS) ? coef[k] : 0);
      chk($sformatf("imp_q[%0d]", k), int'(a_out_q[k]), 0);
    end

    // Negative rounding: -1/1024 impulse on both rails -> zeros, never -1
    push_a(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k < 20; k++) push_a(32'h0, 32'h0);
    wait_a(50, 2000);
    chk("neg_count", a_n, 50);
    for (int k = 30; k < 50; k++) begin
      chk($sformatf("neg_i[%0d]", k), int'(a_out_i[k]), 0);
      chk($sformatf("neg_q[%0d]", k), int'(a_out_q[k]), 0);
    end

    // Step: I=Q=1.0 for 40 pairs -> running coefficient sums, settling at 732
    for (int k = 0; k < 40; k++) push_a(32'h400, 32'h400);
    wait_a(90, 4000);
    chk("step_count", a_n, 90);
    sum = 0;
    for (int k = 0; k < 40; k++) begin
      if (k < TAPS) sum += coef[k];
      chk($sformatf("step_i[%0d]", k), int'(a_out_i[50+k]), sum);
      chk($sformatf("step_q[%0d]", k), int'(a_out_q[50+k]), sum);
    end

    // Decimated results
    for (int c = 0; c < 2000 && b_n < 6; c++) @(negedge clock);
    @(negedge clock);
    chk("dec_count", b_n, 6);
    chk("dec_pops", b_ri, 24);
    for (int g = 0; g < 6; g++) begin
      chk($sformatf("dec_i[%0d]", g), int'(b_out_i[g]), dec_exp[g]);
      chk($sformatf("dec_q[%0d]", g), int'(b_out_q[g]), -dec_exp[g]);
    end

    // Backpressure: I output FIFO full while result is pending
    a_i_full = 1'b1;
    push_a(32'h400, 32'h400);
    push_a(32'h400, 32'h400);
    wait_pop_a(91, 200);
    chk("bp_first_pop", a_ri, 91);
    repeat (TAPS + 5) @(negedge clock);
    chk("bp_din_start", int'(a_i_din), 732);
    repeat (50) @(negedge clock);
    chk("bp_no_push", a_n, 90);
    chk("bp_no_pop", a_ri, 91);
    chk("bp_wr_en", int'(a_i_wr_en), 0);
    chk("bp_i_din_end", int'(a_i_din), 732);
    chk("bp_q_din_end", int'(a_q_din), 732);
    a_i_full = 1'b0;
    wait_a(92, 400);
    repeat (30) @(negedge clock);
    chk("bp_release_count", a_n, 92);
    chk("bp_out0", int'(a_out_i[90]), 732);
    chk("bp_out1", int'(a_out_i[91]), 732);

    // Asynchronous reset in the middle of a MAC pass
    push_a(32'h800, 32'h800);
    wait_pop_a(93, 200);
    chk("rst_mac_pop", a_ri, 93);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_mac_wr_en", int'(a_i_wr_en), 0);
    chk("rst_mac_i_din", int'(a_i_din), 0);
    chk("rst_mac_q_din", int'(a_q_din), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("rst_mac_no_out", a_n, 92);

    // Fresh impulse after reset sees cleared history
    push_a(32'h400, 32'h0);
    for (int k = 1; k < 20; k++) push_a(32'h0, 32'h0);
    wait_a(112, 2000);
    chk("post_rst_count", a_n, 112);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("post_rst_i[%0d]", k), int'(a_out_i[92+k]), coef[k]);
      chk($sformatf("post_rst_q[%0d]", k), int'(a_out_q[92+k]), 0);
    end

    chk("final_i_pops", a_ri, 113);
    chk("final_q_pops", a_rq, 113);
    chk("rd_wr_overlap", a_overlap, 0);
    chk("iq_strobe_pairing", a_pair_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
